// File: rtl/demux1x4_router_pkg.sv
// Shared types and constants for the 1-to-4 demux router.
// Lane indices are 2 bits wide; mode selects static or round-robin targeting.
package demux1x4_router_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_idx_t;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/demux_lane_slot.sv
// One output lane of the router: a single registered entry and its valid bit,
// plus a wrapping count of the words this lane has accepted.
module demux_lane_slot
    import demux1x4_router_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // A load wins over a drain, so a lane can empty and refill in one cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign dout      = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux1x4_router.sv
// 1-to-4 valid/ready demux: each input word goes to the lane picked by s, or
// to the round-robin pointer in RR mode. A full, stalled target blocks input.
module demux1x4_router
    import demux1x4_router_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [1:0]        s,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] I,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] f0,
    output logic [DATA_W-1:0] f1,
    output logic [DATA_W-1:0] f2,
    output logic [DATA_W-1:0] f3,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3,
    output logic [1:0]        rr_ptr
);

    lane_idx_t         rr_ptr_q, rr_ptr_d;
    lane_idx_t         tgt;
    logic              fire;
    logic [3:0]        load;
    logic [DATA_W-1:0] f_arr   [NUM_LANES];
    logic [CNT_W-1:0]  cnt_arr [NUM_LANES];

    assign tgt      = (mode == MODE_SEL) ? s : rr_ptr_q;
    assign in_ready = !out_valid[tgt] || out_ready[tgt];
    assign fire     = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            load[k] = fire && (tgt == lane_idx_t'(k));
        end
    end

    // Pointer only moves on an accepted word in RR mode; a stall never skips.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire && (mode == MODE_RR)) begin
            rr_ptr_d = rr_ptr_q + lane_idx_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .din       (I),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .dout      (f_arr[k]),
            .cnt       (cnt_arr[k])
        );
    end

    assign f0     = f_arr[0];
    assign f1     = f_arr[1];
    assign f2     = f_arr[2];
    assign f3     = f_arr[3];
    assign cnt0   = cnt_arr[0];
    assign cnt1   = cnt_arr[1];
    assign cnt2   = cnt_arr[2];
    assign cnt3   = cnt_arr[3];
    assign rr_ptr = rr_ptr_q;

endmodule
